// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial MSB-first pattern generator for the sequence-detect link.
// Optional HEX_DISPLAY_EN adds registered 7-segment outputs HEX0/HEX3.
module seq_pattern_tx #(
    parameter int                 PAT_LEN  = 8,
    parameter logic [PAT_LEN-1:0] PATTERN  = 8'b11001110,
    parameter int                 TICK_DIV = 8,
    parameter int                 GAP_BITS = 2
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       START,
    input  logic       REPEAT,
    output logic       SER_OUT,
    output logic       SER_VALID,
    output logic       STEP,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] BIT_IDX
`ifdef HEX_DISPLAY_EN
    ,
    output logic [6:0] HEX0,
    output logic [6:0] HEX3
`endif
);

    localparam int PW       = $clog2(TICK_DIV);
    localparam int GAP_CLKS = GAP_BITS * TICK_DIV;
    localparam int GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t             state;
    logic [PW-1:0]      presc;
    logic [GW-1:0]      gap_cnt;
    logic [PAT_LEN-1:0] shreg;

    logic wrap;
    logic last;
    logic gap_end;
    logic frame_end;
    logic load;
    logic adv;

    assign wrap      = (presc == PW'(TICK_DIV - 1));
    assign last      = (BIT_IDX == 4'(PAT_LEN - 1));
    assign gap_end   = (gap_cnt == GW'(GAP_CLKS - 1));
    assign frame_end = (state == SHIFT) && wrap && last;
    assign adv       = (state == SHIFT) && wrap && !last;

    // Reload covers a fresh start, the end of a gap, and back-to-back repeat.
    assign load = ((state == IDLE) && START)
               || ((state == GAP) && gap_end)
               || (frame_end && REPEAT && (GAP_BITS == 0));

`ifdef HEX_DISPLAY_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction
`endif

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= IDLE;
            presc     <= '0;
            gap_cnt   <= '0;
            shreg     <= '0;
            SER_OUT   <= 1'b0;
            SER_VALID <= 1'b0;
            STEP      <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            BIT_IDX   <= '0;
`ifdef HEX_DISPLAY_EN
            HEX0      <= 7'b1111111;
            HEX3      <= 7'b1111111;
`endif
        end else begin
            STEP <= 1'b0;
            DONE <= 1'b0;
            if (load) begin
                state     <= SHIFT;
                shreg     <= PATTERN;
                presc     <= '0;
                gap_cnt   <= '0;
                BIT_IDX   <= '0;
                SER_OUT   <= PATTERN[PAT_LEN-1];
                SER_VALID <= 1'b1;
                BUSY      <= 1'b1;
                STEP      <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        presc <= '0;
                    end
                    SHIFT: begin
                        presc <= wrap ? '0 : presc + 1'b1;
                        if (adv) begin
                            shreg   <= shreg << 1;
                            SER_OUT <= shreg[PAT_LEN-2];
                            BIT_IDX <= BIT_IDX + 4'd1;
                            STEP    <= 1'b1;
                        end else if (frame_end) begin
                            SER_OUT   <= 1'b0;
                            SER_VALID <= 1'b0;
                            BIT_IDX   <= '0;
                            gap_cnt   <= '0;
                            if (REPEAT) begin
                                state <= GAP;
                            end else begin
                                state <= IDLE;
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
`ifdef HEX_DISPLAY_EN
            if (load) begin
                HEX0 <= seg7({3'b000, PATTERN[PAT_LEN-1]});
                HEX3 <= seg7(4'd0);
            end else if (adv) begin
                HEX0 <= seg7({3'b000, shreg[PAT_LEN-2]});
                HEX3 <= seg7(BIT_IDX + 4'd1);
            end else if (state != SHIFT || frame_end) begin
                HEX0 <= 7'b1111111;
                HEX3 <= 7'b1111111;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: scoreboard bench for seq_pattern_tx.
// Expected bits queued at stimulus time, popped on each STEP.
module tb_seq_pattern_tx;

    localparam logic [7:0] PAT = 8'b11001110;

    logic       CLOCK_50 = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       REPEAT = 1'b0;
    logic       SER_OUT, SER_VALID, STEP, BUSY, DONE;
    logic [3:0] BIT_IDX;
    logic       START0 = 1'b0;
    logic       REPEAT0 = 1'b0;
    logic       SER_OUT0, SER_VALID0, STEP0, BUSY0, DONE0;
    logic [3:0] BIT_IDX0;
`ifdef HEX_DISPLAY_EN
    logic [6:0] HEX0, HEX3, HEX0_0, HEX3_0;
`endif

    always #10 CLOCK_50 = ~CLOCK_50;

    seq_pattern_tx dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .START    (START),
        .REPEAT   (REPEAT),
        .SER_OUT  (SER_OUT),
        .SER_VALID(SER_VALID),
        .STEP     (STEP),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .BIT_IDX  (BIT_IDX)
`ifdef HEX_DISPLAY_EN
        ,
        .HEX0     (HEX0),
        .HEX3     (HEX3)
`endif
    );

    seq_pattern_tx #(.GAP_BITS(0)) dut0 (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .START    (START0),
        .REPEAT   (REPEAT0),
        .SER_OUT  (SER_OUT0),
        .SER_VALID(SER_VALID0),
        .STEP     (STEP0),
        .BUSY     (BUSY0),
        .DONE     (DONE0),
        .BIT_IDX  (BIT_IDX0)
`ifdef HEX_DISPLAY_EN
        ,
        .HEX0     (HEX0_0),
        .HEX3     (HEX3_0)
`endif
    );

    typedef struct {
        logic       b;
        logic [3:0] idx;
        int         gap;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_step = 0;
    int   n_done = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_frame(input int first_gap);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.b   = PAT[7-i];
            e.idx = 4'(i);
            e.gap = (i == 0) ? first_gap : 8;
            sbq.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (!RESET) begin
            if (DONE) n_done++;
            if (STEP) begin
                if (sbq.size() == 0) begin
                    check("step_extra", 32'(sbq.size()), 1);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("ser_out", 32'(SER_OUT), 32'(e.b));
                    check("bit_idx", 32'(BIT_IDX), 32'(e.idx));
                    check("ser_valid", 32'(SER_VALID), 1);
                    if (e.gap != 0) check("step_gap", cyc - last_step, e.gap);
                end
                last_step = cyc;
            end
        end
    end

    initial begin
        int s0, rel, nvalid, done_rel, done_first, ngap, d0, nstep, bad;
        int last0;
        logic [23:0] bits;

        // reset
        repeat (3) tick();
        check("reset_out", {SER_OUT, SER_VALID, STEP, BUSY, DONE, BIT_IDX}, 0);
        check("reset_out0", {SER_OUT0, SER_VALID0, STEP0, BUSY0, DONE0, BIT_IDX0}, 0);
`ifdef HEX_DISPLAY_EN
        check("reset_hex", {HEX3, HEX0}, 14'h3FFF);
`endif
        RESET = 1'b0;
        tick();

        // single shot
        push_frame(0);
        d0 = n_done;
        START = 1'b1;
        s0 = cyc;
        tick();
        START = 1'b0;
        nvalid = 0;
        done_rel = 0;
        for (int r = 0; r < 70; r++) begin
            rel = cyc - s0;
            if (SER_VALID) nvalid++;
            if (DONE) done_rel = rel;
            if (rel == 2) check("busy_run", 32'(BUSY), 1);
`ifdef HEX_DISPLAY_EN
            if (rel == 25) begin
                check("hex3_idx3", 32'(HEX3), 32'(7'b0000110));
                check("hex0_bit0", 32'(HEX0), 32'(7'b0000001));
            end
`endif
            tick();
        end
        check("t1_valid_cnt", nvalid, 64);
        check("t1_done_at", done_rel, 65);
        check("t1_done_cnt", n_done - d0, 1);
        check("t1_busy_end", 32'(BUSY), 0);
        check("t1_sb_empty", 32'(sbq.size()), 0);
`ifdef HEX_DISPLAY_EN
        check("hex_idle", {HEX3, HEX0}, 14'h3FFF);
`endif

        // repeat with gap, drop REPEAT in frame 2
        push_frame(0);
        push_frame(24);
        d0 = n_done;
        REPEAT = 1'b1;
        START = 1'b1;
        s0 = cyc;
        tick();
        START = 1'b0;
        nvalid = 0;
        ngap = 0;
        done_rel = 0;
        for (int r = 0; r < 170; r++) begin
            rel = cyc - s0;
            if (rel == 100) REPEAT = 1'b0;
            if (SER_VALID) nvalid++;
            if (rel >= 65 && rel <= 80 && !SER_VALID && !SER_OUT && BUSY) ngap++;
            if (DONE) done_rel = rel;
            tick();
        end
        check("t2_gap_cycles", ngap, 16);
        check("t2_valid_cnt", nvalid, 128);
        check("t2_done_at", done_rel, 145);
        check("t2_done_cnt", n_done - d0, 1);
        check("t2_sb_empty", 32'(sbq.size()), 0);

        // back-to-back frames on the GAP_BITS=0 instance
        REPEAT0 = 1'b1;
        START0 = 1'b1;
        s0 = cyc;
        tick();
        START0 = 1'b0;
        nstep = 0;
        bad = 0;
        bits = '0;
        done_rel = 0;
        last0 = 0;
        for (int r = 0; r < 210; r++) begin
            rel = cyc - s0;
            if (rel == 140) REPEAT0 = 1'b0;
            if (STEP0) begin
                if (nstep > 0 && cyc - last0 != 8) bad++;
                last0 = cyc;
                bits = {bits[22:0], SER_OUT0};
                nstep++;
            end
            if (DONE0) done_rel = rel;
            tick();
        end
        check("t3_steps", nstep, 24);
        check("t3_spacing_bad", bad, 0);
        check("t3_bits", 32'(bits), 32'({PAT, PAT, PAT}));
        check("t3_done_at", done_rel, 193);

        // START held high
        push_frame(0);
        push_frame(9);
        d0 = n_done;
        START = 1'b1;
        s0 = cyc;
        tick();
        done_first = 0;
        done_rel = 0;
        for (int r = 0; r < 140; r++) begin
            rel = cyc - s0;
            if (rel == 100) START = 1'b0;
            if (DONE) begin
                if (done_first == 0) done_first = rel;
                done_rel = rel;
            end
            tick();
        end
        check("t4_done1_at", done_first, 65);
        check("t4_done2_at", done_rel, 130);
        check("t4_done_cnt", n_done - d0, 2);
        check("t4_sb_empty", 32'(sbq.size()), 0);

        // reset while BIT_IDX=4
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            e.b   = PAT[7-i];
            e.idx = 4'(i);
            e.gap = (i == 0) ? 0 : 8;
            sbq.push_back(e);
        end
        d0 = n_done;
        START = 1'b1;
        tick();
        START = 1'b0;
        begin
            int k;
            k = 0;
            while (BIT_IDX != 4'd4 && k < 100) begin
                tick();
                k++;
            end
            check("t5_reach_idx4", 32'(k < 100), 1);
        end
        tick();
        RESET = 1'b1;
        tick();
        check("t5_reset_out", {SER_OUT, SER_VALID, STEP, BUSY, DONE, BIT_IDX}, 0);
        check("t5_sb_empty", 32'(sbq.size()), 0);
        tick();
        RESET = 1'b0;
        repeat (3) tick();
        check("t5_no_done", n_done - d0, 0);
        push_frame(0);
        START = 1'b1;
        s0 = cyc;
        tick();
        START = 1'b0;
        check("t5_restart_idx", 32'(BIT_IDX), 0);
        done_rel = 0;
        for (int r = 0; r < 70; r++) begin
            rel = cyc - s0;
            if (DONE) done_rel = rel;
            tick();
        end
        check("t5_done_at", done_rel, 65);
        check("t5_sb_empty2", 32'(sbq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
